// File: rtl/chip_ram_sdram_responder.sv
// chip_ram_sdram_responder: SDRAM-side responder/checker for the U712 chip RAM
// command bus. It decodes commands as the device sees them and tracks the
// init sequence, the open row and the busy windows. Protocol violations are
// latched in sticky ERR bits, and read/write data strobes are produced.
// Optional feature: define SDRAM_RESP_TIMING_CHECK_EN to build the
// tRCD/tRP/tRFC/auto-precharge timers and the refresh-starvation counter
// (ERR[5:3]). Without it, those bits read 0 and the busy states last one
// enabled cycle.
module chip_ram_sdram_responder #(
  parameter int unsigned CAS_LAT     = 2,
  parameter logic [10:0] MODE_EXPECT = 11'h020
`ifdef SDRAM_RESP_TIMING_CHECK_EN
  ,
  parameter int unsigned TRCD_MIN    = 2,
  parameter int unsigned TRP_MIN     = 2,
  parameter int unsigned TRFC_MIN    = 3,
  parameter int unsigned AP_CYCLES   = 4,
  parameter int unsigned REFRESH_MAX = 310
`endif
) (
  input  logic        CLK40,
  input  logic        REFRESH_RST,
  input  logic        CLK_EN,
  input  logic        SDRAM_CSn,
  input  logic        SDRAM_RASn,
  input  logic        SDRAM_CASn,
  input  logic        SDRAM_WEn,
  input  logic        BANK1,
  input  logic        BANK0,
  input  logic [10:0] CMA,
  output logic        CONFIGURED,
  output logic        ROW_OPEN,
  output logic [9:0]  OPEN_ROW,
  output logic [8:0]  LAST_COL,
  output logic        RD_VALID,
  output logic        WR_STROBE,
  output logic [15:0] REFRESH_COUNT,
  output logic [7:0]  ERR,
  output logic        ERR_ANY
);

  typedef enum logic [2:0] {
    S_INIT_PRE, S_INIT_MRS, S_INIT_REF1, S_INIT_REF2,
    S_IDLE, S_ACTIVE, S_AP_BUSY, S_REFRESHING
  } state_t;

  state_t             state_q;
  logic               configured_q, row_open_q;
  logic [9:0]         open_row_q;
  logic [8:0]         last_col_q;
  logic [CAS_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic               wr_q;
  logic [15:0]        ref_count_q;
  logic [7:0]         err_q, err_d, err_set;
  logic               err_any_q;

  // Enabled commands only; a deselected or clock-disabled cycle decodes as NOP.
  logic c_pre, c_act, c_rd, c_wr, c_ref, c_mrs, c_ill;
  logic cmd_any, c_rw, a10;
  logic busy_hit, trcd_hit, ref_hit, busy_last;

  // Command decode from {RASn,CASn,WEn} while selected and clock-enabled.
  always_comb begin
    c_pre = 1'b0; c_act = 1'b0; c_rd = 1'b0; c_wr = 1'b0;
    c_ref = 1'b0; c_mrs = 1'b0; c_ill = 1'b0;
    if (CLK_EN && !SDRAM_CSn) begin
      case ({SDRAM_RASn, SDRAM_CASn, SDRAM_WEn})
        3'b111:  c_ill = 1'b0;
        3'b010:  c_pre = 1'b1;
        3'b011:  c_act = 1'b1;
        3'b101:  c_rd  = 1'b1;
        3'b100:  c_wr  = 1'b1;
        3'b001:  c_ref = 1'b1;
        3'b000:  c_mrs = 1'b1;
        default: c_ill = 1'b1;
      endcase
    end
  end

  assign cmd_any = c_pre | c_act | c_rd | c_wr | c_ref | c_mrs | c_ill;
  assign c_rw    = c_rd | c_wr;
  assign a10     = CMA[10];

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam int unsigned    RW      = $clog2(REFRESH_MAX + 2);
  localparam logic [RW-1:0]  REF_LIM = RW'(REFRESH_MAX + 1);

  // busy_q covers tRP, tRFC and auto-precharge: it holds the number of
  // further enabled edges at which a non-NOP is still illegal.
  logic [7:0]    busy_q, trcd_q;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;

  // Refresh-interval counter: runs on every CLK40 edge once configured,
  // cleared by AUTOREFRESH, saturates one past the limit.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    if (c_ref)                                        ref_cnt_d = '0;
    else if (configured_q && ref_cnt_q != REF_LIM)    ref_cnt_d = ref_cnt_q + 1'b1;
  end

  assign busy_hit  = cmd_any && (busy_q != 8'd0);
  assign trcd_hit  = c_rw && (trcd_q != 8'd0);
  assign ref_hit   = (ref_cnt_d == REF_LIM);
  assign busy_last = (busy_q <= 8'd1);

  // Timers advance on enabled edges only; the refresh counter free-runs.
  always_ff @(posedge CLK40 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      busy_q    <= '0;
      trcd_q    <= '0;
      ref_cnt_q <= '0;
    end else begin
      if (CLK_EN) begin
        if (c_pre)             busy_q <= 8'(TRP_MIN - 1);
        else if (c_ref)        busy_q <= 8'(TRFC_MIN - 1);
        else if (c_rw && a10)  busy_q <= 8'(AP_CYCLES - 1);
        else if (busy_q != 0)  busy_q <= busy_q - 8'd1;
        if (c_act)             trcd_q <= 8'(TRCD_MIN - 1);
        else if (trcd_q != 0)  trcd_q <= trcd_q - 8'd1;
      end
      ref_cnt_q <= ref_cnt_d;
    end
  end
`else
  assign busy_hit  = 1'b0;
  assign trcd_hit  = 1'b0;
  assign ref_hit   = 1'b0;
  assign busy_last = 1'b1;
`endif

  logic init_st, init_ok;
  assign init_st = (state_q == S_INIT_PRE) || (state_q == S_INIT_MRS) ||
                   (state_q == S_INIT_REF1) || (state_q == S_INIT_REF2);
  assign init_ok = (state_q == S_INIT_PRE  && c_pre) ||
                   (state_q == S_INIT_MRS  && c_mrs) ||
                   (state_q == S_INIT_REF1 && c_ref) ||
                   (state_q == S_INIT_REF2 && c_ref);

  // Violation detection for the command on this edge; several may fire at once.
  always_comb begin
    err_set    = '0;
    err_set[0] = init_st && cmd_any && !init_ok;
    err_set[1] = c_act && row_open_q;
    err_set[2] = c_rw && !row_open_q;
    err_set[3] = trcd_hit;
    err_set[4] = busy_hit;
    err_set[5] = ref_hit;
    err_set[6] = (c_mrs && CMA != MODE_EXPECT) || (cmd_any && {BANK1, BANK0} != 2'b11);
    err_set[7] = c_ill || (c_rw && !a10);
    err_d      = err_q | err_set;
  end

  // Read-latency pipe; frozen while the clock is disabled.
  always_comb begin
    rd_pipe_d = rd_pipe_q;
    if (CLK_EN) begin
      rd_pipe_d[0] = c_rd;
      for (int i = 1; i < CAS_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    end
  end

  // Init and run FSM; a violating command is still followed.
  always_ff @(posedge CLK40 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      state_q      <= S_INIT_PRE;
      configured_q <= 1'b0;
      row_open_q   <= 1'b0;
    end else if (CLK_EN) begin
      case (state_q)
        S_INIT_PRE:  if (c_pre) state_q <= S_INIT_MRS;
        S_INIT_MRS:  if (c_mrs) state_q <= S_INIT_REF1;
        S_INIT_REF1: if (c_ref) state_q <= S_INIT_REF2;
        S_INIT_REF2: if (c_ref) begin
          state_q      <= S_IDLE;
          configured_q <= 1'b1;
        end
        default: begin
          if (c_act) begin
            state_q    <= S_ACTIVE;
            row_open_q <= 1'b1;
          end else if (c_rw && a10) begin
            state_q    <= S_AP_BUSY;
            row_open_q <= 1'b0;
          end else if (c_pre) begin
            state_q    <= S_IDLE;
            row_open_q <= 1'b0;
          end else if (c_ref) begin
            state_q    <= S_REFRESHING;
            row_open_q <= 1'b0;
          end else if ((state_q == S_AP_BUSY || state_q == S_REFRESHING) && busy_last) begin
            state_q    <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Latched address fields, strobes, refresh count and sticky errors.
  always_ff @(posedge CLK40 or posedge REFRESH_RST) begin
    if (REFRESH_RST) begin
      open_row_q  <= '0;
      last_col_q  <= '0;
      rd_pipe_q   <= '0;
      wr_q        <= 1'b0;
      ref_count_q <= '0;
      err_q       <= '0;
      err_any_q   <= 1'b0;
    end else begin
      if (c_act) open_row_q <= CMA[9:0];
      if (c_rw)  last_col_q <= CMA[8:0];
      if (c_ref) ref_count_q <= ref_count_q + 16'd1;
      rd_pipe_q <= rd_pipe_d;
      wr_q      <= c_wr;
      err_q     <= err_d;
      err_any_q <= |err_d;
    end
  end

  assign CONFIGURED    = configured_q;
  assign ROW_OPEN      = row_open_q;
  assign OPEN_ROW      = open_row_q;
  assign LAST_COL      = last_col_q;
  assign RD_VALID      = rd_pipe_q[CAS_LAT-1];
  assign WR_STROBE     = wr_q;
  assign REFRESH_COUNT = ref_count_q;
  assign ERR           = err_q;
  assign ERR_ANY       = err_any_q;

endmodule

// File: tb/tb_chip_ram_sdram_responder.sv
// Directed bench for chip_ram_sdram_responder: init, read/write, tRCD and
// clock suspend, violation flags, refresh starvation and reset mid-read.
module tb_chip_ram_sdram_responder;

  localparam logic [3:0] NOP = 4'b1111, PRE = 4'b0010, ACT = 4'b0011, RD  = 4'b0101,
                         WR  = 4'b0100, REF = 4'b0001, MRS = 4'b0000, ILL = 4'b0110;
`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam logic [7:0] LIVE = 8'hFF;
`else
  localparam logic [7:0] LIVE = 8'hC7;
`endif

  logic        CLK40 = 1'b0, REFRESH_RST = 1'b1, CLK_EN = 1'b1;
  logic        csn = 1'b1, rasn = 1'b1, casn = 1'b1, wen = 1'b1;
  logic        BANK1 = 1'b1, BANK0 = 1'b1;
  logic [10:0] CMA = '0;
  logic        CONFIGURED, ROW_OPEN, RD_VALID, WR_STROBE, ERR_ANY;
  logic [9:0]  OPEN_ROW;
  logic [8:0]  LAST_COL;
  logic [15:0] REFRESH_COUNT;
  logic [7:0]  ERR;
  int          checks = 0, errors = 0;

  chip_ram_sdram_responder dut (
    .CLK40(CLK40), .REFRESH_RST(REFRESH_RST), .CLK_EN(CLK_EN),
    .SDRAM_CSn(csn), .SDRAM_RASn(rasn), .SDRAM_CASn(casn), .SDRAM_WEn(wen),
    .BANK1(BANK1), .BANK0(BANK0), .CMA(CMA),
    .CONFIGURED(CONFIGURED), .ROW_OPEN(ROW_OPEN), .OPEN_ROW(OPEN_ROW),
    .LAST_COL(LAST_COL), .RD_VALID(RD_VALID), .WR_STROBE(WR_STROBE),
    .REFRESH_COUNT(REFRESH_COUNT), .ERR(ERR), .ERR_ANY(ERR_ANY)
  );

  always #5 CLK40 = ~CLK40;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {16'd0, CONFIGURED, ROW_OPEN, OPEN_ROW, LAST_COL, RD_VALID,
            WR_STROBE, REFRESH_COUNT, ERR, ERR_ANY};
  endfunction

  // Drive one command for one edge, return 1ns after that edge.
  task automatic step(input logic [3:0] c, input logic [10:0] a, input logic en);
    {csn, rasn, casn, wen} = c;
    CMA    = a;
    CLK_EN = en;
    @(posedge CLK40); #1;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [10:0] a);
    step(c, a, 1'b1);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(NOP, 11'd0, 1'b1);
  endtask

  task automatic rst_pulse();
    {csn, rasn, casn, wen} = NOP;
    CLK_EN = 1'b1;
    REFRESH_RST = 1'b1;
    #1;
    chk("reset_async_outs", all_outs(), 64'd0);
    @(posedge CLK40); #1;
    REFRESH_RST = 1'b0;
  endtask

  task automatic do_init();
    cmd(PRE, 11'd0);
    nop(1);
    cmd(MRS, 11'h020);
    nop(3);
    cmd(REF, 11'd0);
    nop(3);
    chk("init_not_cfg_yet", {63'd0, CONFIGURED}, 64'd0);
    cmd(REF, 11'd0);
    chk("init_configured", {63'd0, CONFIGURED}, 64'd1);
    chk("init_ref_count", {48'd0, REFRESH_COUNT}, 64'd2);
    chk("init_err", {56'd0, ERR}, 64'd0);
  endtask

  initial begin
    // Reset state
    @(posedge CLK40); #1;
    chk("reset_outs", all_outs(), 64'd0);
    REFRESH_RST = 1'b0;

    // Init and a clean read with auto-precharge
    do_init();
    nop(3);
    cmd(ACT, 11'h2A5);
    chk("rd_row_open", {63'd0, ROW_OPEN}, 64'd1);
    chk("rd_open_row", {54'd0, OPEN_ROW}, 64'h2A5);
    nop(1);
    cmd(RD, 11'h411);
    chk("rd_last_col", {55'd0, LAST_COL}, 64'h011);
    chk("rd_row_closed", {63'd0, ROW_OPEN}, 64'd0);
    chk("rd_valid_n", {63'd0, RD_VALID}, 64'd0);
    nop(1);
    chk("rd_valid_n1", {63'd0, RD_VALID}, 64'd1);
    nop(1);
    chk("rd_valid_n2", {63'd0, RD_VALID}, 64'd0);
    chk("rd_err", {56'd0, ERR}, 64'd0);
    nop(2);

    // Write with auto-precharge
    cmd(ACT, 11'h0F0);
    nop(1);
    cmd(WR, 11'h405);
    chk("wr_strobe", {63'd0, WR_STROBE}, 64'd1);
    chk("wr_last_col", {55'd0, LAST_COL}, 64'h005);
    nop(1);
    chk("wr_strobe_drop", {63'd0, WR_STROBE}, 64'd0);
    chk("wr_err", {56'd0, ERR}, 64'd0);
    nop(3);

    // tRCD violation: READ on the edge right after ACTIVATE
    cmd(ACT, 11'h155);
    cmd(RD, 11'h422);
    chk("trcd_err", {56'd0, ERR}, {56'd0, 8'h08 & LIVE});
    nop(1);
    chk("trcd_rd_valid", {63'd0, RD_VALID}, 64'd1);
    nop(4);

    // Clock suspend after READ delays RD_VALID; suspended commands ignored
    cmd(ACT, 11'h100);
    nop(1);
    cmd(RD, 11'h433);
    for (int i = 0; i < 3; i++) begin
      step(ILL, 11'd0, 1'b0);
      chk("susp_rd_valid_low", {63'd0, RD_VALID}, 64'd0);
    end
    nop(1);
    chk("susp_rd_valid_high", {63'd0, RD_VALID}, 64'd1);
    nop(1);
    chk("susp_rd_valid_drop", {63'd0, RD_VALID}, 64'd0);
    chk("susp_err", {56'd0, ERR}, {56'd0, 8'h08 & LIVE});

    // Out-of-order command during init with a bad bank
    rst_pulse();
    BANK0 = 1'b0;
    cmd(ACT, 11'h3FF);
    BANK0 = 1'b1;
    chk("order_bank_err", {56'd0, ERR}, 64'h41);
    chk("order_open_row", {54'd0, OPEN_ROW}, 64'h3FF);
    chk("order_err_any", {63'd0, ERR_ANY}, 64'd1);

    // Violation flags accumulate and persist
    rst_pulse();
    do_init();
    nop(3);
    cmd(RD, 11'h400);
    chk("viol_no_row", {56'd0, ERR}, 64'h04);
    nop(4);
    cmd(ACT, 11'h001);
    nop(2);
    cmd(ACT, 11'h002);
    chk("viol_act_twice", {56'd0, ERR}, 64'h06);
    cmd(MRS, 11'h030);
    chk("viol_mode", {56'd0, ERR}, 64'h46);
    cmd(ILL, 11'd0);
    chk("viol_illegal", {56'd0, ERR}, 64'hC6);
    nop(3);
    chk("viol_sticky", {56'd0, ERR}, 64'hC6);
    chk("viol_err_any", {63'd0, ERR_ANY}, 64'd1);

    // Refresh starvation
    rst_pulse();
    do_init();
    nop(310);
    chk("starve_310", {56'd0, ERR}, 64'd0);
    nop(1);
    chk("starve_311", {56'd0, ERR}, {56'd0, 8'h20 & LIVE});

    // Reset in the middle of a READ discards the pending RD_VALID
    cmd(ACT, 11'h0AA);
    nop(1);
    cmd(RD, 11'h400);
    REFRESH_RST = 1'b1;
    #1;
    chk("midrd_outs", all_outs(), 64'd0);
    @(posedge CLK40); #1;
    REFRESH_RST = 1'b0;
    nop(1);
    chk("midrd_no_pulse_a", {63'd0, RD_VALID}, 64'd0);
    nop(1);
    chk("midrd_no_pulse_b", {63'd0, RD_VALID}, 64'd0);
    chk("midrd_cfg", {63'd0, CONFIGURED}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
